// File: rtl/seq_run_detector.sv
// Detects runs of RUN_LEN consecutive bits matching a run-time polarity on serial input x.
// Optional longest-run tracking (max_run / max_clr) is enabled by defining SEQ_RUN_MAXLEN_EN.
module seq_run_detector #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             pol,
`ifdef SEQ_RUN_MAXLEN_EN
  input  logic             max_clr,
  output logic [CNT_W-1:0] max_run,
`endif
  output logic             y,
  output logic             det_pulse,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HIT    = 2'b10,
    UNUSED = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] MAXV   = '1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] run_len_next;
  logic             hit;
  logic             m;

  assign m = en & (x == pol);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // run_len_next is also consumed by the longest-run tracker.
  always_comb begin
    state_next   = state;
    run_len_next = run_len;
    hit          = 1'b0;
    if (state == UNUSED) begin
      state_next   = IDLE;
      run_len_next = '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (m) begin
            state_next   = RUN;
            run_len_next = CNT_W'(1);
          end else begin
            run_len_next = '0;
          end
        end
        RUN: begin
          if (m) begin
            run_len_next = run_len + 1'b1;
            if (run_len == THRESH) begin
              state_next = HIT;
              hit        = 1'b1;
            end
          end else begin
            state_next   = IDLE;
            run_len_next = '0;
          end
        end
        HIT: begin
          if (m) begin
            if (run_len != MAXV) run_len_next = run_len + 1'b1;
          end else begin
            state_next   = IDLE;
            run_len_next = '0;
          end
        end
        default: begin
          state_next   = IDLE;
          run_len_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    y       = ~reset & m & (run_len >= THRESH);
    state_o = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_len   <= '0;
      hit_cnt   <= '0;
      det_pulse <= 1'b0;
    end else begin
      run_len   <= run_len_next;
      det_pulse <= hit;
      if (hit && (hit_cnt != MAXV)) hit_cnt <= hit_cnt + 1'b1;
    end
  end

`ifdef SEQ_RUN_MAXLEN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      max_run <= '0;
    end else if (max_clr) begin
      max_run <= '0;
    end else if (run_len_next > max_run) begin
      max_run <= run_len_next;
    end
  end
`endif

endmodule

// File: tb/tb_seq_run_detector.sv
// Bench for seq_run_detector: two instances (CNT_W=8 and CNT_W=2, RUN_LEN=3) against a run-counting model.
// Checks max_run as well when SEQ_RUN_MAXLEN_EN is defined.
module tb_seq_run_detector;

  localparam int RL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, x, pol;
  logic       y_a, dp_a, y_b, dp_b;
  logic [7:0] rl_a, hc_a;
  logic [1:0] rl_b, hc_b;
  logic [1:0] st_a, st_b;
`ifdef SEQ_RUN_MAXLEN_EN
  logic       max_clr;
  logic [7:0] mr_a;
  logic [1:0] mr_b;
`endif

  int ncmp = 0;
  int nerr = 0;

  // Model: unbounded count of consecutive matching bits, runs that reached RL, longest run.
  int cnt[2];
  int hits[2];
  int mx[2];
  bit pend[2];
  int maxv[2] = '{255, 3};

  seq_run_detector #(.RUN_LEN(RL), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .en(en), .x(x), .pol(pol),
`ifdef SEQ_RUN_MAXLEN_EN
    .max_clr(max_clr), .max_run(mr_a),
`endif
    .y(y_a), .det_pulse(dp_a), .run_len(rl_a), .hit_cnt(hc_a), .state_o(st_a)
  );

  seq_run_detector #(.RUN_LEN(RL), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .en(en), .x(x), .pol(pol),
`ifdef SEQ_RUN_MAXLEN_EN
    .max_clr(max_clr), .max_run(mr_b),
`endif
    .y(y_b), .det_pulse(dp_b), .run_len(rl_b), .hit_cnt(hc_b), .state_o(st_b)
  );

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic int st_of(input int c);
    if (c == 0) return 0;
    if (c < RL) return 1;
    return 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit xv, input bit p, input bit c);
    bit mt;
    reset = r; en = e; x = xv; pol = p;
`ifdef SEQ_RUN_MAXLEN_EN
    max_clr = c;
`endif
    #1;
    mt = (xv == p);
    chk("y_a", {31'b0, y_a}, {31'b0, (!r && e && mt && (cnt[0] + 1 >= RL))});
    chk("y_b", {31'b0, y_b}, {31'b0, (!r && e && mt && (cnt[1] + 1 >= RL))});
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        cnt[k] = 0; hits[k] = 0; pend[k] = 1'b0;
      end else if (e) begin
        if (mt) begin
          cnt[k]++;
          pend[k] = (cnt[k] == RL);
          if (pend[k]) hits[k]++;
        end else begin
          cnt[k] = 0; pend[k] = 1'b0;
        end
      end else begin
        pend[k] = 1'b0;
      end
      if (r || c) mx[k] = 0;
      else if (sat(cnt[k], maxv[k]) > mx[k]) mx[k] = sat(cnt[k], maxv[k]);
    end
    @(posedge clk);
    #1;
    chk("run_len_a", 32'(rl_a), sat(cnt[0], maxv[0]));
    chk("hit_cnt_a", 32'(hc_a), sat(hits[0], maxv[0]));
    chk("det_pulse_a", {31'b0, dp_a}, {31'b0, pend[0]});
    chk("state_a", 32'(st_a), st_of(cnt[0]));
    chk("run_len_b", 32'(rl_b), sat(cnt[1], maxv[1]));
    chk("hit_cnt_b", 32'(hc_b), sat(hits[1], maxv[1]));
    chk("det_pulse_b", {31'b0, dp_b}, {31'b0, pend[1]});
    chk("state_b", 32'(st_b), st_of(cnt[1]));
`ifdef SEQ_RUN_MAXLEN_EN
    chk("max_run_a", 32'(mr_a), mx[0]);
    chk("max_run_b", 32'(mr_b), mx[1]);
`endif
  endtask

  initial begin
    bit r, e, xv, p, c;
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; hits[k] = 0; mx[k] = 0; pend[k] = 1'b0;
    end
    reset = 1'b1; en = 1'b0; x = 1'b0; pol = 1'b1;
`ifdef SEQ_RUN_MAXLEN_EN
    max_clr = 1'b0;
`endif
    @(posedge clk);
    #1;

    // Reset state
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 1, 1, 0);
    chk("reset_state", 32'(st_a), 0);
    chk("reset_hit_cnt", 32'(hc_a), 0);

    // Ones run: 0,1,1,1,1,0
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    chk("plan1_pulse", {31'b0, dp_a}, 32'd1);
    cyc(0, 1, 1, 1, 0);
    chk("plan1_len4", 32'(rl_a), 4);
    cyc(0, 1, 0, 1, 0);
    chk("plan1_hits", 32'(hc_a), 1);

    // Zeros run with pol=0: 1,0,0,0,1
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("plan2_state_hit", 32'(st_a), 2);
    cyc(0, 1, 1, 0, 0);
    chk("plan2_hits", 32'(hc_a), 1);

    // Enable gap does not break the run
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("gap_hold", 32'(rl_a), 2);
    cyc(0, 1, 1, 1, 0);

    // Reset mid-run
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);
    chk("midrst_len", 32'(rl_a), 0);
    chk("midrst_state", 32'(st_a), 0);

    // Saturation on the narrow instance
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 1, 0);
      cyc(0, 1, 1, 1, 0);
      cyc(0, 1, 1, 1, 0);
      cyc(0, 1, 0, 1, 0);
    end
    chk("sat_hits_b", 32'(hc_b), 3);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 1, 0);
    chk("sat_len_b", 32'(rl_b), 3);
    cyc(0, 1, 0, 1, 0);

    // Longest-run tracking: 4 ones, 2 ones, clear, 1 one
    cyc(1, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0);
`ifdef SEQ_RUN_MAXLEN_EN
    chk("max_run_4", 32'(mr_a), 4);
`endif
    cyc(0, 1, 0, 1, 1);
`ifdef SEQ_RUN_MAXLEN_EN
    chk("max_run_clr", 32'(mr_a), 0);
`endif
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 0);
`ifdef SEQ_RUN_MAXLEN_EN
    chk("max_run_1", 32'(mr_a), 1);
`endif

    // Randomized traffic, biased toward long runs
    p = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 24) == 0) p = ~p;
      xv = ($urandom_range(0, 3) != 0) ? p : ~p;
      c  = ($urandom_range(0, 39) == 0);
      cyc(r, e, xv, p, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
